vga_text_writer: RTL and testbench

VGA_TEXT_WRITER -- requirements
Module: vga_text_writer

---
 rtl/vga_text_writer.sv | 238 +++++++++++++++++++++++
 tb/tb_vga_text_writer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_writer.sv
// Text-mode writer: turns a character stream into character/colour map writes, tracks the cursor,
// clears each new row on row advance, and clears the whole screen on 0x0C when
// VGA_TEXT_WRITER_CLEAR_SCREEN_EN is defined (otherwise 0x0C is swallowed and CLEAR_SCREEN is not built).
module vga_text_writer #(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            char_data_i,
  input  logic [7:0]            char_attr_i,
  input  logic                  char_valid_i,
  output logic                  char_ready_o,
  output logic [ADDR_WIDTH-1:0] ch_map_addr_o,
  output logic [7:0]            ch_map_data_o,
  output logic                  ch_map_wen_o,
  output logic [ADDR_WIDTH-1:0] col_map_addr_o,
  output logic [7:0]            col_map_data_o,
  output logic                  col_map_wen_o,
  output logic [6:0]            cursor_col_o,
  output logic [4:0]            cursor_row_o,
  output logic                  busy_o
);

  // Handshake: a character is consumed on every rising edge where char_valid_i and
  // char_ready_o are both high; char_ready_o depends only on state and rst_i, never on valid.

  localparam logic [7:0] SPACE = 8'h20;

`ifdef VGA_TEXT_WRITER_CLEAR_SCREEN_EN
  localparam int CELLS = COLS * ROWS;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CLEAR_LINE   = 2'd1,
    CLEAR_SCREEN = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLEAR_LINE = 2'd1
  } state_t;
`endif

  state_t                state;
  state_t                state_next;

  logic [6:0]            col;
  logic [4:0]            row;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [7:0]            clr_attr;

  logic                  take;
  logic                  is_print;
  logic                  is_cr;
  logic                  is_lf;
  logic                  is_bs;
  logic                  at_last_col;
  logic                  row_adv;
  logic                  clr_last;
`ifdef VGA_TEXT_WRITER_CLEAR_SCREEN_EN
  logic                  is_ff;
  logic                  ff_go;
`endif

  logic                  wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [7:0]            wr_ch_d;
  logic [7:0]            wr_col_d;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [7:0]            wr_ch_q;
  logic [7:0]            wr_col_q;

  assign char_ready_o = (state == IDLE) && !rst_i;
  assign busy_o       = (state != IDLE);
  assign take         = char_valid_i && (state == IDLE) && !rst_i;

  assign is_print    = (char_data_i >= 8'h20);
  assign is_cr       = (char_data_i == 8'h0D);
  assign is_lf       = (char_data_i == 8'h0A);
  assign is_bs       = (char_data_i == 8'h08);
  assign at_last_col = (col == 7'(COLS - 1));
  assign row_adv     = take && ((is_print && at_last_col) || is_lf);
`ifdef VGA_TEXT_WRITER_CLEAR_SCREEN_EN
  assign is_ff = (char_data_i == 8'h0C);
  assign ff_go = take && is_ff;
`endif

  // Both map ports share one set of registers so they can never disagree.
  assign ch_map_addr_o  = wr_addr_q;
  assign col_map_addr_o = wr_addr_q;
  assign ch_map_wen_o   = wr_en_q;
  assign col_map_wen_o  = wr_en_q;
  assign ch_map_data_o  = wr_ch_q;
  assign col_map_data_o = wr_col_q;
  assign cursor_col_o   = col;
  assign cursor_row_o   = row;

  always_comb begin
    clr_last = 1'b0;
    case (state)
      CLEAR_LINE:   clr_last = (clr_cnt == ADDR_WIDTH'(COLS - 1));
`ifdef VGA_TEXT_WRITER_CLEAR_SCREEN_EN
      CLEAR_SCREEN: clr_last = (clr_cnt == ADDR_WIDTH'(CELLS - 1));
`endif
      default:      clr_last = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
`ifdef VGA_TEXT_WRITER_CLEAR_SCREEN_EN
        if (ff_go) begin
          state_next = CLEAR_SCREEN;
        end else if (row_adv) begin
          state_next = CLEAR_LINE;
        end
`else
        if (row_adv) begin
          state_next = CLEAR_LINE;
        end
`endif
      end
      CLEAR_LINE: begin
        if (clr_last) begin
          state_next = IDLE;
        end
      end
`ifdef VGA_TEXT_WRITER_CLEAR_SCREEN_EN
      CLEAR_SCREEN: begin
        if (clr_last) begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Output logic: the write request for the next cycle
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = row_base + ADDR_WIDTH'(col);
    wr_ch_d   = char_data_i;
    wr_col_d  = char_attr_i;
    case (state)
      IDLE: begin
        wr_en_d = take && is_print;
      end
      CLEAR_LINE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = row_base + clr_cnt;
        wr_ch_d   = SPACE;
        wr_col_d  = clr_attr;
      end
`ifdef VGA_TEXT_WRITER_CLEAR_SCREEN_EN
      CLEAR_SCREEN: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_cnt;
        wr_ch_d   = SPACE;
        wr_col_d  = clr_attr;
      end
`endif
      default: wr_en_d = 1'b0;
    endcase
  end

  // Datapath: registered write port, cursor, row base and clear counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_ch_q   <= '0;
      wr_col_q  <= '0;
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      clr_cnt   <= '0;
      clr_attr  <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_ch_q   <= wr_ch_d;
      wr_col_q  <= wr_col_d;

      if (take) begin
        clr_cnt  <= '0;
        clr_attr <= char_attr_i;
      end else if (state != IDLE) begin
        clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
      end

      if (take) begin
        if (is_print) begin
          col <= at_last_col ? 7'd0 : col + 7'd1;
        end else if (is_cr || is_lf) begin
          col <= '0;
        end else if (is_bs) begin
          if (col != 7'd0) begin
            col <= col - 7'd1;
          end
`ifdef VGA_TEXT_WRITER_CLEAR_SCREEN_EN
        end else if (is_ff) begin
          col      <= '0;
          row      <= '0;
          row_base <= '0;
`endif
        end
      end

      // row_base tracks row*COLS incrementally; wrapping to row 0 resets it.
      if (row_adv) begin
        if (row == 5'(ROWS - 1)) begin
          row      <= '0;
          row_base <= '0;
        end else begin
          row      <= row + 5'd1;
          row_base <= row_base + ADDR_WIDTH'(COLS);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// Self-checking bench for vga_text_writer: directed table, hand-written corner sequences,
// and randomized characters checked against a cursor/write-list reference model.
module tb_vga_text_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int AW    = 12;
  localparam int CELLS = COLS * ROWS;
`ifdef VGA_TEXT_WRITER_CLEAR_SCREEN_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [7:0]    char_data;
  logic [7:0]    char_attr;
  logic          char_valid;
  logic          char_ready;
  logic [AW-1:0] ch_map_addr;
  logic [7:0]    ch_map_data;
  logic          ch_map_wen;
  logic [AW-1:0] col_map_addr;
  logic [7:0]    col_map_data;
  logic          col_map_wen;
  logic [6:0]    cursor_col;
  logic [4:0]    cursor_row;
  logic          busy;

  vga_text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .char_data_i    (char_data),
    .char_attr_i    (char_attr),
    .char_valid_i   (char_valid),
    .char_ready_o   (char_ready),
    .ch_map_addr_o  (ch_map_addr),
    .ch_map_data_o  (ch_map_data),
    .ch_map_wen_o   (ch_map_wen),
    .col_map_addr_o (col_map_addr),
    .col_map_data_o (col_map_data),
    .col_map_wen_o  (col_map_wen),
    .cursor_col_o   (cursor_col),
    .cursor_row_o   (cursor_row),
    .busy_o         (busy)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Reference model: cursor as (col,row), cell address = row*COLS+col, expected writes queued
  int m_col  = 0;
  int m_row  = 0;
  int m_busy = 0;
  logic [31:0] exp_q[$];

  task automatic push_wr(input int addr, input logic [7:0] ch, input logic [7:0] at);
    exp_q.push_back({16'(addr), ch, at});
  endtask

  task automatic model_advance(input logic [7:0] at);
    m_row = (m_row + 1) % ROWS;
    for (int i = 0; i < COLS; i++) push_wr(m_row * COLS + i, 8'h20, at);
    m_busy = COLS;
  endtask

  task automatic model_apply(input logic [7:0] d, input logic [7:0] at);
    m_busy = 0;
    if (d >= 8'h20) begin
      push_wr(m_row * COLS + m_col, d, at);
      if (m_col == COLS - 1) begin
        m_col = 0;
        model_advance(at);
      end else begin
        m_col++;
      end
    end else if (d == 8'h0D) begin
      m_col = 0;
    end else if (d == 8'h0A) begin
      m_col = 0;
      model_advance(at);
    end else if (d == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (d == 8'h0C && FF_EN) begin
      for (int i = 0; i < CELLS; i++) push_wr(i, 8'h20, at);
      m_col  = 0;
      m_row  = 0;
      m_busy = CELLS;
    end
  endtask

  // Scoreboard: every observed write must match the head of the expected queue
  always @(negedge clk) begin
    if (ch_map_wen === 1'b1 || col_map_wen === 1'b1) begin
      check("wen_pair", 32'(col_map_wen), 32'(ch_map_wen));
      check("addr_pair", 32'(col_map_addr), 32'(ch_map_addr));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0d ch=0x%0h attr=0x%0h expected=none",
                 ch_map_addr, ch_map_data, col_map_data);
      end else begin
        check("write", {16'(ch_map_addr), ch_map_data, col_map_data}, exp_q.pop_front());
      end
    end
  end

  // Driver tasks (called at a falling edge, return at a falling edge)
  task automatic start_char(input logic [7:0] d, input logic [7:0] a);
    int guard = 0;
    while (char_ready !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (char_ready !== 1'b1) check("ready_timeout", 32'(char_ready), 32'd1);
    char_data  = d;
    char_attr  = a;
    char_valid = 1'b1;
    model_apply(d, a);
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (char_ready !== 1'b1 && cyc < 5000) begin
      check("busy_while_clearing", 32'(busy), 32'd1);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic send_and_check(input string tag, input logic [7:0] d, input logic [7:0] a,
                                input int ec, input int er, input int eb);
    int cyc;
    start_char(d, a);
    wait_idle(cyc);
    check({tag, "_busy_cycles"}, 32'(cyc), 32'(eb));
    check({tag, "_col"}, 32'(cursor_col), 32'(ec));
    check({tag, "_row"}, 32'(cursor_row), 32'(er));
  endtask

  task automatic do_reset(input int cycles);
    rst        = 1'b1;
    char_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic abort_clear(input logic [7:0] d, input int target);
    int guard = 0;
    start_char(d, 8'h5A);
    while (!(ch_map_wen === 1'b1 && ch_map_addr == AW'(target)) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reached_target", 32'(ch_map_addr), 32'(target));
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_wen_low", 32'(ch_map_wen), 32'd0);
      check("abort_ready_low", 32'(char_ready), 32'd0);
    end
    check("abort_cursor", {cursor_col, cursor_row}, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_ready_after_release", 32'(char_ready), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] attr;
    int         exp_col;
    int         exp_row;
    int         exp_busy;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int r;
    int cyc;
    logic [7:0] d;
    logic [7:0] a;
    int rr;

    rr = FF_EN ? 0 : 1;
    vecs[0]  = '{8'h41, 8'h1F, 1, 0, 0};
    vecs[1]  = '{8'h42, 8'h2E, 2, 0, 0};
    vecs[2]  = '{8'h08, 8'h00, 1, 0, 0};
    vecs[3]  = '{8'h08, 8'h00, 0, 0, 0};
    vecs[4]  = '{8'h08, 8'h00, 0, 0, 0};
    vecs[5]  = '{8'h43, 8'h4C, 1, 0, 0};
    vecs[6]  = '{8'h0D, 8'h00, 0, 0, 0};
    vecs[7]  = '{8'h0A, 8'h35, 0, 1, COLS};
    vecs[8]  = '{8'h00, 8'h11, 0, 1, 0};
    vecs[9]  = '{8'h1B, 8'h22, 0, 1, 0};
    vecs[10] = '{8'h0C, 8'h70, 0, rr, FF_EN ? CELLS : 0};
    vecs[11] = '{8'hFF, 8'h9A, 1, rr, 0};
    vecs[12] = '{8'h7F, 8'h01, 2, rr, 0};
    vecs[13] = '{8'h20, 8'h02, 3, rr, 0};

    // Reset values while reset is held
    rst        = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    char_attr  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(char_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wen", {31'd0, ch_map_wen | col_map_wen}, 32'd0);
    check("rst_addr", 32'(ch_map_addr), 32'd0);
    check("rst_data", {16'd0, ch_map_data, col_map_data}, 32'd0);
    check("rst_cursor", {cursor_col, cursor_row}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_release", 32'(char_ready), 32'd1);
    @(negedge clk);

    // First write: registered, one-cycle strobe, cursor advance
    char_data  = 8'h41;
    char_attr  = 8'h1F;
    char_valid = 1'b1;
    model_apply(8'h41, 8'h1F);
    @(negedge clk);
    char_valid = 1'b0;
    check("first_wen", {31'd0, ch_map_wen & col_map_wen}, 32'd1);
    check("first_addr", 32'(ch_map_addr), 32'd0);
    check("first_ch", 32'(ch_map_data), 32'h41);
    check("first_attr", 32'(col_map_data), 32'h1F);
    check("first_cursor", {cursor_col, cursor_row}, {20'd0, 7'd1, 5'd0});
    @(negedge clk);
    check("first_wen_drop", {31'd0, ch_map_wen | col_map_wen}, 32'd0);

    // Directed table
    do_reset(2);
    for (int i = 0; i < 14; i++) begin
      send_and_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].attr,
                     vecs[i].exp_col, vecs[i].exp_row, vecs[i].exp_busy);
    end

    // Full row of printables: wrap, then line clear of row 1
    do_reset(1);
    for (int i = 0; i < COLS; i++) begin
      send_and_check("row_fill", 8'($urandom_range(32, 255)), 8'($urandom_range(0, 255)),
                     (i == COLS - 1) ? 0 : i + 1, (i == COLS - 1) ? 1 : 0,
                     (i == COLS - 1) ? COLS : 0);
    end

    // Down to the last row, then LF wraps to row 0 and clears it
    for (int i = 0; i < ROWS - 2; i++) send_and_check("lf_down", 8'h0A, 8'h13, 0, i + 2, COLS);
    for (int i = 0; i < 5; i++) send_and_check("last_row_txt", 8'h61, 8'h07, i + 1, ROWS - 1, 0);
    send_and_check("lf_wrap", 8'h0A, 8'h44, 0, 0, COLS);
    send_and_check("after_wrap", 8'h5A, 8'h66, 1, 0, 0);

    // Backspace at column 0, carriage return mid-row
    do_reset(1);
    for (int i = 0; i < 3; i++) send_and_check("lf_to3", 8'h0A, 8'h10, 0, i + 1, COLS);
    send_and_check("bs_col0", 8'h08, 8'h10, 0, 3, 0);
    for (int i = 0; i < 12; i++) send_and_check("txt_row3", 8'h30, 8'h21, i + 1, 3, 0);
    send_and_check("cr_row3", 8'h0D, 8'h21, 0, 3, 0);

    // Reset in the middle of a clear
    do_reset(1);
    if (FF_EN) abort_clear(8'h0C, 1000);
    else       abort_clear(8'h0A, COLS + 40);

    // Randomized characters against the model
    do_reset(1);
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      d = 8'($urandom_range(32, 255));
      else if (r < 78) d = 8'h08;
      else if (r < 85) d = 8'h0D;
      else if (r < 90) d = 8'h0A;
      else if (r < 92) d = 8'h0C;
      else             d = 8'($urandom_range(0, 31));
      a = 8'($urandom_range(0, 255));
      start_char(d, a);
      wait_idle(cyc);
      check("rand_busy_cycles", 32'(cyc), 32'(m_busy));
      check("rand_cursor", {cursor_col, cursor_row}, {20'd0, 7'(m_col), 5'(m_row)});
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
